// File: rtl/c2c_r_cache.sv
// Direct-mapped, one-word-per-line read-only cache between the core read port and memory.
// Misses refill through a second read-protocol port; flush bulk-invalidates every line.
module c2c_r_cache #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LINES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [XLEN/8-1:0] sel,
    input  logic [XLEN-1:0]   addr,
    output logic              ack,
    output logic [XLEN-1:0]   data,
    output logic              mem_re,
    output logic [XLEN/8-1:0] mem_sel,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              flush
);

    localparam int unsigned BYTES  = XLEN / 8;
    localparam int unsigned OFF    = $clog2(BYTES);
    localparam int unsigned IDXW   = $clog2(LINES);
    localparam int unsigned WADDRW = XLEN - OFF;
    localparam int unsigned TAGW   = WADDRW - IDXW;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t              state, state_nx;
    logic [WADDRW-1:0]   req_waddr, req_waddr_nx;
    logic [XLEN-1:0]     refill_word, refill_word_nx;
    logic                flushed, flushed_nx;
    logic                ack_nx;
    logic [XLEN-1:0]     data_nx;
    logic                mem_re_nx;
    logic [BYTES-1:0]    mem_sel_nx;
    logic [XLEN-1:0]     mem_addr_nx;
    logic                line_we;

    logic [LINES-1:0]    valid;
    logic [TAGW-1:0]     tag_mem  [LINES];
    logic [XLEN-1:0]     data_mem [LINES];

    logic [IDXW-1:0]     req_idx;
    logic [TAGW-1:0]     req_tag;
    logic                hit;

    assign req_idx = req_waddr[IDXW-1:0];
    assign req_tag = req_waddr[WADDRW-1:IDXW];
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // Byte selects and the byte offset never influence the returned word.
    logic unused_bits;
    assign unused_bits = ^{sel, addr[OFF-1:0]};

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nx       = state;
        req_waddr_nx   = req_waddr;
        refill_word_nx = refill_word;
        flushed_nx     = flushed | flush;
        ack_nx         = 1'b0;
        data_nx        = data;
        mem_re_nx      = mem_re;
        mem_sel_nx     = mem_sel;
        mem_addr_nx    = mem_addr;
        line_we        = 1'b0;

        case (state)
            IDLE: begin
                // re is still high in the ack cycle of the previous request
                if (re && !ack) begin
                    req_waddr_nx = addr[XLEN-1:OFF];
                    state_nx     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ack_nx   = 1'b1;
                    data_nx  = data_mem[req_idx];
                    state_nx = IDLE;
                end else begin
                    mem_re_nx   = 1'b1;
                    mem_sel_nx  = '1;
                    mem_addr_nx = {req_waddr, {OFF{1'b0}}};
                    flushed_nx  = 1'b0;
                    state_nx    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    refill_word_nx = mem_data;
                    line_we        = !(flushed || flush);
                    mem_re_nx      = 1'b0;
                    mem_sel_nx     = '0;
                    mem_addr_nx    = '0;
                    state_nx       = RESP;
                end
            end
            RESP: begin
                ack_nx   = 1'b1;
                data_nx  = refill_word;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_waddr   <= '0;
            refill_word <= '0;
            flushed     <= 1'b0;
            ack         <= 1'b0;
            data        <= '0;
            mem_re      <= 1'b0;
            mem_sel     <= '0;
            mem_addr    <= '0;
        end else begin
            state       <= state_nx;
            req_waddr   <= req_waddr_nx;
            refill_word <= refill_word_nx;
            flushed     <= flushed_nx;
            ack         <= ack_nx;
            data        <= data_nx;
            mem_re      <= mem_re_nx;
            mem_sel     <= mem_sel_nx;
            mem_addr    <= mem_addr_nx;
        end
    end

    // Valid bits: flush has priority over a concurrent refill write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (line_we) begin
            valid[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_c2c_r_cache.sv
// Self-checking bench for c2c_r_cache: directed vector table, hand-written corner
// sequences, then random reads checked against an array-based cache model.
module tb_c2c_r_cache;

    logic        clk;
    logic        rst_n;
    logic        re;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        mem_re;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;

    c2c_r_cache #(.XLEN(32), .LINES(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .re       (re),
        .sel      (sel),
        .addr     (addr),
        .ack      (ack),
        .data     (data),
        .mem_re   (mem_re),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        int          w;      // memory wait cycles after mem_re rises
        logic [31:0] mw;     // word memory returns
        int          f;      // cycle of a one-cycle flush pulse, -1 none
        logic        hit;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[16];

    bit          m_valid[64];
    logic [31:0] m_tag[64];
    logic [31:0] m_data[64];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One core read starting at a negedge (cycle 0 = first cycle re is high).
    // Plays memory: mem_ack w cycles after mem_re is first seen.
    task automatic do_read(input logic [31:0] a, input logic [3:0] s, input int w,
                           input logic [31:0] mw, input int f,
                           output int lat, output logic [31:0] rdata, output int mre_at,
                           output logic [31:0] maddr, output logic [3:0] msel, output int extra);
        int c;
        int ack_cyc;
        lat = -1; rdata = '0; mre_at = -1; maddr = '0; msel = '0; extra = 0; ack_cyc = -1;
        re = 1'b1; addr = a; sel = s; flush = (f == 0);
        c = 0;
        while (lat < 0 && c < 40) begin
            @(negedge clk);
            c++;
            flush   = (c == f);
            mem_ack = 1'b0;
            if (mem_re && mre_at < 0) begin
                mre_at  = c;
                maddr   = mem_addr;
                msel    = mem_sel;
                ack_cyc = c + w;
            end
            if (c == ack_cyc) begin
                mem_ack  = 1'b1;
                mem_data = mw;
            end
            if (ack) begin
                lat   = c;
                rdata = data;
                re    = 1'b0;
            end
        end
        @(negedge clk);
        flush   = 1'b0;
        mem_ack = 1'b0;
        if (ack) extra = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        re = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          lat, mre_at, extra, acks, idx, f, w, r;
        int          ack_at[4];
        logic [31:0] rd, ma, a, wa, tg, exp_d;
        logic [3:0]  ms, s;
        logic        hit;

        tbl[0]  = '{32'h0000_0104, 4'hF, 3, 32'hDEAD_BEEF, -1, 1'b0, 32'hDEAD_BEEF};
        tbl[1]  = '{32'h0000_0104, 4'hF, 0, 32'h0,         -1, 1'b1, 32'hDEAD_BEEF};
        tbl[2]  = '{32'h0000_0204, 4'hF, 0, 32'hCAFE_0204, -1, 1'b0, 32'hCAFE_0204};
        tbl[3]  = '{32'h0000_0104, 4'hF, 2, 32'hDEAD_BEEF, -1, 1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{32'h0000_0204, 4'hF, 1, 32'hCAFE_0204, -1, 1'b0, 32'hCAFE_0204};
        tbl[5]  = '{32'h0000_0107, 4'h2, 0, 32'hDEAD_BEEF, -1, 1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{32'h0000_0106, 4'h1, 0, 32'h0,         -1, 1'b1, 32'hDEAD_BEEF};
        tbl[7]  = '{32'h0000_0300, 4'hF, 2, 32'h1234_5678,  3, 1'b0, 32'h1234_5678};
        tbl[8]  = '{32'h0000_0300, 4'hF, 0, 32'h1234_5678, -1, 1'b0, 32'h1234_5678};
        tbl[9]  = '{32'h0000_0300, 4'hF, 0, 32'h0,         -1, 1'b1, 32'h1234_5678};
        tbl[10] = '{32'h0000_0104, 4'hF, 0, 32'hDEAD_BEEF, -1, 1'b0, 32'hDEAD_BEEF};
        tbl[11] = '{32'h0000_0400, 4'hF, 1, 32'h4444_0000,  3, 1'b0, 32'h4444_0000};
        tbl[12] = '{32'h0000_0400, 4'hF, 0, 32'h4444_0000, -1, 1'b0, 32'h4444_0000};
        tbl[13] = '{32'h0000_0400, 4'hF, 0, 32'h0,         -1, 1'b1, 32'h4444_0000};
        tbl[14] = '{32'h0000_0400, 4'hF, 0, 32'h0,          1, 1'b1, 32'h4444_0000};
        tbl[15] = '{32'h0000_0400, 4'hF, 0, 32'h4444_0000, -1, 1'b0, 32'h4444_0000};

        rst_n = 1'b0; re = 1'b0; sel = '0; addr = '0;
        mem_ack = 1'b0; mem_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_sel", 32'(mem_sel), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            do_read(tbl[i].a, tbl[i].s, tbl[i].w, tbl[i].mw, tbl[i].f, lat, rd, mre_at, ma, ms, extra);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].hit ? 2 : 4 + tbl[i].w);
            check($sformatf("tbl%0d_data", i), rd, tbl[i].d);
            check($sformatf("tbl%0d_mem_re_cycle", i), mre_at, tbl[i].hit ? -1 : 2);
            if (!tbl[i].hit) begin
                check($sformatf("tbl%0d_mem_addr", i), ma, tbl[i].a & ~32'h3);
                check($sformatf("tbl%0d_mem_sel", i), 32'(ms), 32'hF);
            end
            check($sformatf("tbl%0d_extra_ack", i), extra, 0);
        end

        // Reset asserted in the middle of a refill
        do_read(32'h100, 4'hF, 0, 32'h0100_AAAA, -1, lat, rd, mre_at, ma, ms, extra);
        check("rstseq_fill_data", rd, 32'h0100_AAAA);
        do_read(32'h100, 4'hF, 0, 32'h0, -1, lat, rd, mre_at, ma, ms, extra);
        check("rstseq_fill_hit", mre_at, -1);
        re = 1'b1; addr = 32'h500; sel = 4'hF;
        repeat (3) @(negedge clk);
        check("rstseq_mem_re_before", 32'(mem_re), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstseq_mem_re_in_reset", 32'(mem_re), 32'd0);
        check("rstseq_ack_in_reset", 32'(ack), 32'd0);
        re = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_ack = 1'b0;
        acks = 0;
        repeat (3) begin
            if (ack || mem_re) acks++;
            @(negedge clk);
        end
        check("rstseq_late_mem_ack_ignored", acks, 0);
        do_read(32'h100, 4'hF, 1, 32'h0100_AAAA, -1, lat, rd, mre_at, ma, ms, extra);
        check("rstseq_reread_miss", mre_at, 2);
        check("rstseq_reread_data", rd, 32'h0100_AAAA);

        // re held high across four hits
        for (int k = 0; k < 4; k++) ack_at[k] = -1;
        acks = 0;
        re = 1'b1; addr = 32'h100; sel = 4'hF;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ack) begin
                if (acks < 4) ack_at[acks] = c;
                acks++;
                check($sformatf("b2b_data%0d", acks), data, 32'h0100_AAAA);
                if (acks == 4) re = 1'b0;
            end
        end
        check("b2b_ack_count", acks, 4);
        for (int k = 0; k < 4; k++) check($sformatf("b2b_ack_cycle%0d", k), ack_at[k], 2 + 3 * k);

        // Random reads against the model
        do_reset();
        for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
        for (int t = 0; t < 200; t++) begin
            a  = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(7, 0)) << 2) | 32'($urandom_range(3, 0));
            s  = 4'($urandom_range(15, 0));
            w  = int'($urandom_range(3, 0));
            r  = int'($urandom_range(11, 0));
            f  = (r < 3) ? r : -1;
            wa = a & ~32'h3;
            idx = int'((a >> 2) % 64);
            tg  = a >> 8;
            if (f == 0) for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            hit   = m_valid[idx] && (m_tag[idx] == tg);
            exp_d = hit ? m_data[idx] : mem_fn(wa);
            if (f >= 1) for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            if (!hit && f != 2) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = mem_fn(wa);
            end
            do_read(a, s, w, mem_fn(wa), f, lat, rd, mre_at, ma, ms, extra);
            check($sformatf("rnd%0d_latency a=%08h", t, a), lat, hit ? 2 : 4 + w);
            check($sformatf("rnd%0d_data a=%08h", t, a), rd, exp_d);
            check($sformatf("rnd%0d_mem_re_cycle a=%08h", t, a), mre_at, hit ? -1 : 2);
            if (!hit) check($sformatf("rnd%0d_mem_addr", t), ma, wa);
            check($sformatf("rnd%0d_extra_ack", t), extra, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c2c_r_cache.md
# c2c_r_cache

Direct-mapped, read-only cache on the responder (slave) side of the core-to-cache read interface: it accepts core read requests (re/sel/addr), answers with data/ack, and refills misses through a second instance of the same read protocol toward memory, acting there as initiator (master). It sits between the core fetch/load port and the memory bus. Lines are one word wide; there is no write path, only a bulk invalidate.

## Interface
- XLEN, 32, data/address width; XLEN/8 byte lanes.
- LINES, 64, number of cache lines; power of two, at least 2.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- re  input  1  core read request; held high with addr/sel stable until ack.
- sel  input  XLEN/8  byte select; accepted, not used (full word always returned).
- addr  input  XLEN  core byte address; low log2(XLEN/8) bits ignored.
- ack  output  1  one-cycle pulse; data valid in the same cycle.
- data  output  XLEN  read word for the acknowledged request.
- mem_re  output  1  refill request to memory.
- mem_sel  output  XLEN/8  always all ones while mem_re is high, else 0.
- mem_addr  output  XLEN  word-aligned refill address (low bits zero).
- mem_ack  input  1  memory response pulse; mem_data valid that cycle.
- mem_data  input  XLEN  refill word.
- flush  input  1  invalidate all lines; single-cycle pulse or held.

## Operation
- Address split: OFF = log2(XLEN/8) low bits ignored; IDX = next log2(LINES) bits; TAG = remaining XLEN-OFF-IDX bits.
- Storage: per line valid bit, tag, data word. All valid bits cleared by reset and by flush.
- States: IDLE, LOOKUP, REFILL, RESP.
- IDLE: re high -> capture addr into request register, go LOOKUP. re low -> stay.
- LOOKUP: compare stored tag/valid at IDX. Hit -> drive data from line, ack=1, go IDLE. Miss -> go REFILL, mem_re=1 from next cycle.
- REFILL: mem_re=1, mem_addr = captured addr with OFF bits zeroed; held until mem_ack. On mem_ack: latch mem_data, write data/tag and set valid at IDX, go RESP.
- RESP: ack=1, data = latched refill word, go IDLE.
- In the ack cycle re is still high from the finished request and is not treated as a new request; the next request is sampled in IDLE the cycle after.
- flush: clears all valid bits at the clock edge where it is high. During LOOKUP the lookup in that cycle is evaluated against pre-flush state. If flush is high at any point during REFILL (including the mem_ack cycle), the refill word is still returned to the core but the line is not marked valid.
- Changing addr or dropping re before ack is a protocol violation; behaviour undefined except no deadlock: the in-flight refill always completes.
- Reset mid-operation: state -> IDLE, mem_re dropped immediately; any late mem_ack is ignored.

## Timing
- Reset values: ack=0, data=0, mem_re=0, mem_sel=0, mem_addr=0; state IDLE; all valid=0.
- All outputs registered (state-decoded from flops); no combinational path from re/addr or mem_ack to any output.
- Hit: re first high in cycle N -> ack in cycle N+2. Max hit throughput: one ack per 3 cycles.
- Miss: re first high in cycle N -> mem_re high from N+2; mem_ack in cycle M -> ack in cycle M+2 (M+1 RESP registered). Minimum miss latency with zero-wait memory (mem_ack at N+2): ack at N+4.
- data holds its last value outside ack cycles.
- mem_re, mem_addr, mem_sel stable from assertion until the cycle after mem_ack, when mem_re returns to 0.

## Test plan
- Reset: assert rst_n=0 mid-REFILL -> mem_re=0 and ack=0 same cycle; after release, read of 0x100 misses (valid cleared).
- Cold miss then hit: read 0x0000_0104, memory returns 0xDEAD_BEEF after 3 wait cycles -> mem_addr=0x104, mem_sel=0xF, one ack with data 0xDEAD_BEEF; repeat read -> ack at N+2, no mem_re.
- Conflict: read 0x104 then 0x204 (same IDX, LINES=64) -> second misses, refills, evicts; third read of 0x104 misses again.
- Misaligned/sel: read addr 0x107, sel=0x2 -> mem_addr=0x104, full word returned.
- Flush during refill: flush pulse while mem_re high -> core receives refill word; immediate reread of same address misses.
- Back-to-back: re held high across 4 hits -> exactly 4 ack pulses, one per 3 cycles, no extra ack.
